// File: rtl/mmio_hub_pkg.sv
// Shared definitions for the MMIO hub: address windows and timer register map.
package mmio_hub_pkg;

  typedef enum logic [3:0] {
    WIN_MEM = 4'd0,
    WIN_LED = 4'd1,
    WIN_SEG = 4'd2,
    WIN_SW  = 4'd3,
    WIN_TMR = 4'd4
  } win_e;

  localparam logic [1:0] TMR_LOAD   = 2'd0;
  localparam logic [1:0] TMR_CTRL   = 2'd1;
  localparam logic [1:0] TMR_STATUS = 2'd2;
  localparam logic [1:0] TMR_COUNT  = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_AUTO_BIT  = 1;
  localparam int STATUS_EXP_BIT = 0;

  // The window is selected by the top nibble of the processor address.
  function automatic logic [3:0] window_of(input logic [15:0] addr);
    return addr[15:12];
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Programmable interval timer: LOAD/CTRL/STATUS/COUNT registers, prescaler and tick logic.
module mmio_timer
  import mmio_hub_pkg::*;
#(
  parameter int TIMER_W  = 16,
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [1:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        irq_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [TIMER_W-1:0] load_q, load_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               en_q, en_d;
  logic               auto_q, auto_d;
  logic               exp_q, exp_d;
  logic               ctrl_wr;
  logic               tick;
  logic               unused_wdata;

  assign unused_wdata = ^wdata_i;
  assign irq_o = exp_q;

  // Next-state: a CTRL write overrides any tick in the same cycle; expiry beats a STATUS clear.
  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;
    en_d    = en_q;
    auto_d  = auto_q;
    exp_d   = exp_q;
    ctrl_wr = wr_en_i && (addr_i == TMR_CTRL);
    tick    = en_q && (presc_q == PRESC_MAX);

    if (wr_en_i && (addr_i == TMR_LOAD))
      load_d = wdata_i[TIMER_W-1:0];
    if (wr_en_i && (addr_i == TMR_STATUS) && wdata_i[STATUS_EXP_BIT])
      exp_d = 1'b0;
    if (en_q)
      presc_d = tick ? '0 : presc_q + 1'b1;

    if (ctrl_wr) begin
      en_d   = wdata_i[CTRL_EN_BIT];
      auto_d = wdata_i[CTRL_AUTO_BIT];
      if (wdata_i[CTRL_EN_BIT] && !en_q) begin
        count_d = load_q;
        presc_d = '0;
      end
    end else if (tick) begin
      if (count_q == '0) begin
        exp_d = 1'b1;
        if (auto_q) count_d = load_q;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Timer state register, cleared asynchronously even mid-count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      exp_q   <= exp_d;
    end
  end

  // Register read port; the hub registers this to give one-cycle read latency.
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      TMR_LOAD:   rdata_o = 16'(load_q);
      TMR_CTRL:   rdata_o = {14'd0, auto_q, en_q};
      TMR_STATUS: rdata_o = {15'd0, exp_q};
      TMR_COUNT:  rdata_o = 16'(count_q);
      default:    rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: address decode, LED/seg7/switch registers and the registered read-data mux.
module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int LED_W    = 9,
  parameter int SW_W     = 9,
  parameter int N_DIGITS = 6,
  parameter int TIMER_W  = 16,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           ADDR,
  input  logic [15:0]           DOUT,
  input  logic                  W,
  output logic [15:0]           DIN,
  input  logic [15:0]           mem_q,
  output logic                  mem_wren,
  input  logic [SW_W-1:0]       SW,
  output logic [LED_W-1:0]      LEDR,
  output logic [7*N_DIGITS-1:0] HEX,
  output logic                  tmr_irq
);

  logic [3:0]      win;
  logic [2:0]      digit;
  logic [LED_W-1:0] led_q;
  logic [6:0]      seg_q [N_DIGITS];
  logic [SW_W-1:0] sync1_q, sync2_q, sw_q;
  logic [15:0]     rdata_d, rdata_q;
  logic [15:0]     tmr_rdata;
  logic [6:0]      seg_rd;
  logic            mem_sel_q;
  logic            unused_addr;

  assign win         = window_of(ADDR);
  assign digit       = ADDR[2:0];
  assign unused_addr = ^ADDR[11:3];
  assign mem_wren    = W && (win == WIN_MEM);
  assign LEDR        = led_q;
  assign DIN         = mem_sel_q ? mem_q : rdata_q;

  mmio_timer #(
    .TIMER_W  (TIMER_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (W && (win == WIN_TMR)),
    .addr_i  (ADDR[1:0]),
    .wdata_i (DOUT),
    .rdata_o (tmr_rdata),
    .irq_o   (tmr_irq)
  );

  // LED register loads the low bits of the write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        led_q <= '0;
    else if (W && (win == WIN_LED)) led_q <= DOUT[LED_W-1:0];
  end

  // Digit pattern storage; writes to non-existent digits fall through the loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) seg_q[i] <= '0;
    end else if (W && (win == WIN_SEG)) begin
      for (int i = 0; i < N_DIGITS; i++)
        if (digit == 3'(i)) seg_q[i] <= DOUT[6:0];
    end
  end

  // Segments are active-low, so an all-zero pattern blanks the digit.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_hex
    assign HEX[7*g +: 7] = ~seg_q[g];
  end

  // Two-flop synchroniser for the raw switches followed by the sampled register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
    end else begin
      sync1_q <= SW;
      sync2_q <= sync1_q;
      sw_q    <= sync2_q;
    end
  end

  // Peripheral read data for the current address; unmapped digits and windows read zero.
  always_comb begin
    seg_rd = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (digit == 3'(i)) seg_rd = seg_q[i];
    rdata_d = '0;
    case (win)
      WIN_LED: rdata_d = 16'(led_q);
      WIN_SEG: rdata_d = {9'd0, seg_rd};
      WIN_SW:  rdata_d = 16'(sw_q);
      WIN_TMR: rdata_d = tmr_rdata;
      default: rdata_d = '0;
    endcase
  end

  // Register window select and peripheral data to match the memory's read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_sel_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      mem_sel_q <= (win == WIN_MEM);
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mmio_hub.sv
// Directed testbench for mmio_hub with a fast timer prescaler.
module tb_mmio_hub;

  localparam int LED_W    = 9;
  localparam int SW_W     = 9;
  localparam int N_DIGITS = 6;
  localparam int TIMER_W  = 16;
  localparam int PRESCALE = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [15:0]           ADDR;
  logic [15:0]           DOUT;
  logic                  W;
  logic [15:0]           DIN;
  logic [15:0]           mem_q;
  logic                  mem_wren;
  logic [SW_W-1:0]       SW;
  logic [LED_W-1:0]      LEDR;
  logic [7*N_DIGITS-1:0] HEX;
  logic                  tmr_irq;

  int checkCount = 0;
  int failCount  = 0;
  logic [63:0] expHex;

  mmio_hub #(
    .LED_W    (LED_W),
    .SW_W     (SW_W),
    .N_DIGITS (N_DIGITS),
    .TIMER_W  (TIMER_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ADDR     (ADDR),
    .DOUT     (DOUT),
    .W        (W),
    .DIN      (DIN),
    .mem_q    (mem_q),
    .mem_wren (mem_wren),
    .SW       (SW),
    .LEDR     (LEDR),
    .HEX      (HEX),
    .tmr_irq  (tmr_irq)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One bus cycle driven from a falling edge; returns on the next falling edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic wr);
    ADDR = a;
    DOUT = d;
    W    = wr;
    @(negedge clk);
    W    = 1'b0;
  endtask

  // Immediate comparison that tallies and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence: reset, LED, seg7, switches, memory, unmapped, then timer modes.
  initial begin
    ADDR = '0; DOUT = '0; W = 1'b0; SW = '0; mem_q = 16'hBEEF;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h1000, 16'h00AA, 1'b1);
    applyStimulus(16'h2001, 16'h007F, 1'b1);
    applyStimulus(16'h4001, 16'h0003, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("irq_before_reset", 64'(tmr_irq), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_ledr", 64'(LEDR), 64'd0);
    checkOutput("reset_hex", 64'(HEX), 64'({42{1'b1}}));
    checkOutput("reset_din", 64'(DIN), 64'd0);
    checkOutput("reset_irq", 64'(tmr_irq), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h4003, 16'h0000, 1'b0);
    checkOutput("reset_count", 64'(DIN), 64'd0);
    applyStimulus(16'h4001, 16'h0000, 1'b0);
    checkOutput("reset_ctrl", 64'(DIN), 64'd0);

    applyStimulus(16'h1000, 16'h01A5, 1'b1);
    checkOutput("led_write", 64'(LEDR), 64'h1A5);
    applyStimulus(16'h1000, 16'h0000, 1'b0);
    checkOutput("led_read", 64'(DIN), 64'h01A5);
    applyStimulus(16'h1000, 16'hFFFF, 1'b1);
    checkOutput("led_trunc", 64'(LEDR), 64'h1FF);
    applyStimulus(16'h1000, 16'h0000, 1'b0);
    checkOutput("led_read_full", 64'(DIN), 64'h01FF);
    applyStimulus(16'h5000, 16'h1234, 1'b1);
    checkOutput("unmapped_write", 64'(LEDR), 64'h1FF);
    applyStimulus(16'h5000, 16'h0000, 1'b0);
    checkOutput("unmapped_read", 64'(DIN), 64'h0000);

    applyStimulus(16'h2002, 16'h003F, 1'b1);
    applyStimulus(16'h2007, 16'h007F, 1'b1);
    expHex = 64'({42{1'b1}});
    expHex[20:14] = 7'h40;
    checkOutput("seg_hex", 64'(HEX), expHex);
    applyStimulus(16'h2002, 16'h0000, 1'b0);
    checkOutput("seg_read2", 64'(DIN), 64'h003F);
    applyStimulus(16'h2007, 16'h0000, 1'b0);
    checkOutput("seg_read7", 64'(DIN), 64'h0000);

    applyStimulus(16'h3000, 16'h0000, 1'b0);
    checkOutput("sw_initial", 64'(DIN), 64'h0000);
    SW = 9'h0F0;
    repeat (3) @(negedge clk);
    checkOutput("sw_cycle3", 64'(DIN), 64'h0000);
    @(negedge clk);
    checkOutput("sw_cycle4", 64'(DIN), 64'h00F0);

    applyStimulus(16'h0123, 16'h0000, 1'b0);
    checkOutput("mem_read", 64'(DIN), 64'hBEEF);
    mem_q = 16'h1234;
    #1;
    checkOutput("mem_mux", 64'(DIN), 64'h1234);
    ADDR = 16'h0010; W = 1'b1;
    #1;
    checkOutput("mem_wren_hi", 64'(mem_wren), 64'd1);
    ADDR = 16'h1000;
    #1;
    checkOutput("mem_wren_lo", 64'(mem_wren), 64'd0);
    W = 1'b0;
    @(negedge clk);

    applyStimulus(16'h4000, 16'h0002, 1'b1);
    applyStimulus(16'h4001, 16'h0003, 1'b1);
    repeat (11) @(negedge clk);
    checkOutput("auto_irq_c11", 64'(tmr_irq), 64'd0);
    @(negedge clk);
    checkOutput("auto_irq_c12", 64'(tmr_irq), 64'd1);
    applyStimulus(16'h4003, 16'h0000, 1'b0);
    checkOutput("auto_reload", 64'(DIN), 64'd2);
    applyStimulus(16'h4002, 16'h0001, 1'b1);
    checkOutput("status_clear", 64'(tmr_irq), 64'd0);
    repeat (9) @(negedge clk);
    applyStimulus(16'h4002, 16'h0001, 1'b1);
    checkOutput("set_beats_clear", 64'(tmr_irq), 64'd1);

    applyStimulus(16'h4001, 16'h0000, 1'b1);
    applyStimulus(16'h4002, 16'h0001, 1'b1);
    checkOutput("stop_clear", 64'(tmr_irq), 64'd0);
    applyStimulus(16'h4000, 16'h0000, 1'b1);
    applyStimulus(16'h4001, 16'h0001, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("oneshot_c3", 64'(tmr_irq), 64'd0);
    @(negedge clk);
    checkOutput("oneshot_c4", 64'(tmr_irq), 64'd1);
    applyStimulus(16'h4001, 16'h0000, 1'b0);
    checkOutput("oneshot_en", 64'(DIN), 64'd0);
    repeat (8) @(negedge clk);
    applyStimulus(16'h4003, 16'h0000, 1'b0);
    checkOutput("oneshot_count", 64'(DIN), 64'd0);
    applyStimulus(16'h4002, 16'h0000, 1'b0);
    checkOutput("oneshot_status", 64'(DIN), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule
